// File: rtl/intt_ctrl_if.sv
// intt_ctrl_if: start/status plus coefficient RAM, twiddle ROM and write-back
// addressing for one inverse-NTT controller.
// Optional feature macro: INTT_SCALE_EN (adds scale_sel for the final 1/N pass).
interface intt_ctrl_if;
    logic       start;
    logic       busy;
    logic       done;
    logic [3:0] stage;
    logic       rd_en;
    logic [7:0] rd_addr_a;
    logic [7:0] rd_addr_b;
    logic [7:0] tw_addr;
    logic       wr_a_en;
    logic       wr_b_en;
    logic [7:0] wr_addr_a;
    logic [7:0] wr_addr_b;
`ifdef INTT_SCALE_EN
    logic       scale_sel;
`endif

    modport master (
`ifdef INTT_SCALE_EN
        output scale_sel,
`endif
        input  start,
        output busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
               wr_a_en, wr_b_en, wr_addr_a, wr_addr_b
    );

    modport slave (
`ifdef INTT_SCALE_EN
        input  scale_sel,
`endif
        output start,
        input  busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
               wr_a_en, wr_b_en, wr_addr_a, wr_addr_b
    );
endinterface

// File: rtl/intt_ctrl.sv
// intt_ctrl: address/sequence controller for one Dilithium inverse NTT (N=256)
// driving bu_intt. Walks 8 Gentleman-Sande stages, one butterfly per cycle, and
// delays every issued pair by RD_LAT+BU_LAT cycles to form write-back addresses.
// Optional feature macro: INTT_SCALE_EN (appends a 256-issue scaling pass).
module intt_ctrl #(
    parameter int BU_LAT = 36,
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    intt_ctrl_if.master bus
);
    localparam int D = RD_LAT + BU_LAT;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_DRAIN  = 3'd2,
        S_SCALE  = 3'd3,
        S_SDRAIN = 3'd4,
        S_FIN    = 3'd5
    } state_t;

    // Offset mask len-1 for stage s, where len = 1 << s.
    function automatic logic [6:0] off_mask(input logic [2:0] s);
        return 7'h7F >> (3'd7 - s);
    endfunction

    state_t     state_r, state_nxt_s;
    logic [6:0] bfly_r, bfly_nxt_s;
    logic [2:0] stage_r, stage_nxt_s;
    logic [7:0] k_r, k_nxt_s;
`ifdef INTT_SCALE_EN
    logic [7:0] sidx_r, sidx_nxt_s;
    logic       sc_s, sc_r;
`endif

    logic       grp_end_s;
    logic       dl_last_s;
    logic [6:0] nmask_s;
    logic [7:0] nlen_s;
    logic [7:0] j_s;

    logic       busy_s, done_s, rd_en_s;
    logic [3:0] stage_s;
    logic [7:0] rd_a_s, rd_b_s, tw_s;
    logic       busy_r, done_r, rd_en_r;
    logic [3:0] stage_out_r;
    logic [7:0] rd_a_r, rd_b_r, tw_r;

    logic [D-1:0] dl_wa_r;
    logic [D-1:0] dl_wb_r;
    logic [7:0]   dl_a_r [D];
    logic [7:0]   dl_b_r [D];
    logic         dl_in_wa_s;
    logic [7:0]   dl_in_a_s, dl_in_b_s;

    // Last butterfly of a group: the twiddle index moves on after it.
    assign grp_end_s = ((bfly_r & off_mask(stage_r)) == off_mask(stage_r));
    // Final write of a pass is leaving the delay line and nothing follows it.
    assign dl_last_s = dl_wb_r[D-1] && !(|dl_wb_r[D-2:0]);

    // Butterfly-to-address mapping for the upcoming cycle: j = g*2*len + o.
    assign nmask_s = off_mask(stage_nxt_s);
    assign nlen_s  = {1'b0, nmask_s} + 8'd1;
    assign j_s     = {bfly_nxt_s & ~nmask_s, 1'b0} | {1'b0, bfly_nxt_s & nmask_s};

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            bfly_r  <= 7'd0;
            stage_r <= 3'd0;
            k_r     <= 8'd0;
`ifdef INTT_SCALE_EN
            sidx_r  <= 8'd0;
`endif
        end else begin
            state_r <= state_nxt_s;
            bfly_r  <= bfly_nxt_s;
            stage_r <= stage_nxt_s;
            k_r     <= k_nxt_s;
`ifdef INTT_SCALE_EN
            sidx_r  <= sidx_nxt_s;
`endif
        end
    end

    // Next-state and counter update logic.
    always_comb begin
        state_nxt_s = state_r;
        bfly_nxt_s  = bfly_r;
        stage_nxt_s = stage_r;
        k_nxt_s     = k_r;
`ifdef INTT_SCALE_EN
        sidx_nxt_s  = sidx_r;
`endif
        case (state_r)
            S_IDLE: begin
                if (bus.start) begin
                    state_nxt_s = S_ISSUE;
                    bfly_nxt_s  = 7'd0;
                    stage_nxt_s = 3'd0;
                    k_nxt_s     = 8'd255;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_ISSUE: begin
                bfly_nxt_s = bfly_r + 7'd1;
                if (grp_end_s) begin
                    k_nxt_s = k_r - 8'd1;
                end else begin
                    k_nxt_s = k_r;
                end
                if (bfly_r == 7'd127) begin
                    state_nxt_s = S_DRAIN;
                end else begin
                    state_nxt_s = S_ISSUE;
                end
            end
            S_DRAIN: begin
                if (dl_last_s) begin
                    if (stage_r == 3'd7) begin
`ifdef INTT_SCALE_EN
                        state_nxt_s = S_SCALE;
                        sidx_nxt_s  = 8'd0;
`else
                        state_nxt_s = S_FIN;
`endif
                    end else begin
                        state_nxt_s = S_ISSUE;
                        stage_nxt_s = stage_r + 3'd1;
                    end
                end else begin
                    state_nxt_s = S_DRAIN;
                end
            end
`ifdef INTT_SCALE_EN
            S_SCALE: begin
                sidx_nxt_s = sidx_r + 8'd1;
                if (sidx_r == 8'd255) begin
                    state_nxt_s = S_SDRAIN;
                end else begin
                    state_nxt_s = S_SCALE;
                end
            end
            S_SDRAIN: begin
                if (dl_last_s) begin
                    state_nxt_s = S_FIN;
                end else begin
                    state_nxt_s = S_SDRAIN;
                end
            end
`endif
            S_FIN:   state_nxt_s = S_IDLE;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state; addresses are zero when idle.
    always_comb begin
        busy_s  = 1'b0;
        done_s  = 1'b0;
        stage_s = 4'd0;
        rd_en_s = 1'b0;
        rd_a_s  = 8'd0;
        rd_b_s  = 8'd0;
        tw_s    = 8'd0;
`ifdef INTT_SCALE_EN
        sc_s    = 1'b0;
`endif
        case (state_nxt_s)
            S_ISSUE: begin
                busy_s  = 1'b1;
                stage_s = {1'b0, stage_nxt_s};
                rd_en_s = 1'b1;
                rd_a_s  = j_s;
                rd_b_s  = j_s + nlen_s;
                tw_s    = k_nxt_s;
            end
            S_DRAIN: begin
                busy_s  = 1'b1;
                stage_s = {1'b0, stage_nxt_s};
            end
`ifdef INTT_SCALE_EN
            S_SCALE: begin
                busy_s  = 1'b1;
                stage_s = 4'd8;
                rd_en_s = 1'b1;
                rd_a_s  = sidx_nxt_s;
                sc_s    = 1'b1;
            end
            S_SDRAIN: begin
                busy_s  = 1'b1;
                stage_s = 4'd8;
            end
`endif
            S_FIN:   done_s = 1'b1;
            default: busy_s = 1'b0;
        endcase
    end

    // Registered status and read-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            stage_out_r <= 4'd0;
            rd_en_r     <= 1'b0;
            rd_a_r      <= 8'd0;
            rd_b_r      <= 8'd0;
            tw_r        <= 8'd0;
`ifdef INTT_SCALE_EN
            sc_r        <= 1'b0;
`endif
        end else begin
            busy_r      <= busy_s;
            done_r      <= done_s;
            stage_out_r <= stage_s;
            rd_en_r     <= rd_en_s;
            rd_a_r      <= rd_a_s;
            rd_b_r      <= rd_b_s;
            tw_r        <= tw_s;
`ifdef INTT_SCALE_EN
            sc_r        <= sc_s;
`endif
        end
    end

`ifdef INTT_SCALE_EN
    // The scale pass only writes B_Out, back to the coefficient it read.
    assign dl_in_wa_s = rd_en_r & ~sc_r;
    assign dl_in_a_s  = sc_r ? 8'd0 : rd_a_r;
    assign dl_in_b_s  = sc_r ? rd_a_r : rd_b_r;
`else
    assign dl_in_wa_s = rd_en_r;
    assign dl_in_a_s  = rd_a_r;
    assign dl_in_b_s  = rd_b_r;
`endif

    // Issue-to-write delay line: entry D-1 is the write issued D cycles ago.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl_wa_r <= {D{1'b0}};
            dl_wb_r <= {D{1'b0}};
            for (int i = 0; i < D; i++) begin
                dl_a_r[i] <= 8'd0;
                dl_b_r[i] <= 8'd0;
            end
        end else begin
            dl_wa_r   <= {dl_wa_r[D-2:0], dl_in_wa_s};
            dl_wb_r   <= {dl_wb_r[D-2:0], rd_en_r};
            dl_a_r[0] <= dl_in_a_s;
            dl_b_r[0] <= dl_in_b_s;
            for (int i = 1; i < D; i++) begin
                dl_a_r[i] <= dl_a_r[i-1];
                dl_b_r[i] <= dl_b_r[i-1];
            end
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.stage     = stage_out_r;
    assign bus.rd_en     = rd_en_r;
    assign bus.rd_addr_a = rd_a_r;
    assign bus.rd_addr_b = rd_b_r;
    assign bus.tw_addr   = tw_r;
    assign bus.wr_a_en   = dl_wa_r[D-1];
    assign bus.wr_b_en   = dl_wb_r[D-1];
    assign bus.wr_addr_a = dl_a_r[D-1];
    assign bus.wr_addr_b = dl_b_r[D-1];
`ifdef INTT_SCALE_EN
    assign bus.scale_sel = sc_r;
`endif
endmodule

// File: tb/tb_intt_ctrl.sv
// tb_intt_ctrl: self-checking bench for intt_ctrl (BU_LAT=36, RD_LAT=1).
// Honours INTT_SCALE_EN when the design is built with it.
module tb_intt_ctrl;
    localparam int D = 37;
`ifdef INTT_SCALE_EN
    localparam int DONE_CYC = 8 * (128 + D) + 256 + D + 1;
`else
    localparam int DONE_CYC = 8 * (128 + D) + 1;
`endif
    localparam int LAST = DONE_CYC + 10;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic [3:0] stage;
        logic       rd_en;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] tw;
        logic       wa;
        logic       wb;
        logic [7:0] wra;
        logic [7:0] wrb;
        logic       sc;
    } out_t;

    typedef struct {
        int   cyc;
        logic start;
        out_t exp;
    } vec_t;

    logic  clk = 1'b0;
    logic  rst_n;
    int    n_tests;
    int    n_fail;
    out_t  exp_q [0:LAST];
    vec_t  tbl [$];
    out_t  zero_o;

    intt_ctrl_if bus ();

    intt_ctrl #(.BU_LAT(36), .RD_LAT(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic out_t sample();
        out_t o;
        o.busy  = bus.busy;
        o.done  = bus.done;
        o.stage = bus.stage;
        o.rd_en = bus.rd_en;
        o.a     = bus.rd_addr_a;
        o.b     = bus.rd_addr_b;
        o.tw    = bus.tw_addr;
        o.wa    = bus.wr_a_en;
        o.wb    = bus.wr_b_en;
        o.wra   = bus.wr_addr_a;
        o.wrb   = bus.wr_addr_b;
`ifdef INTT_SCALE_EN
        o.sc    = bus.scale_sel;
`else
        o.sc    = 1'b0;
`endif
        return o;
    endfunction

    function automatic out_t mk(bit bz, bit dn, int st, bit re, int a, int b, int tw,
                                bit wa, bit wb, int wra, int wrb, bit sc);
        out_t o;
        o.busy = bz;  o.done = dn;  o.stage = 4'(st); o.rd_en = re;
        o.a = 8'(a);  o.b = 8'(b);  o.tw = 8'(tw);
        o.wa = wa;    o.wb = wb;    o.wra = 8'(wra);  o.wrb = 8'(wrb);
        o.sc = sc;
        return o;
    endfunction

    // Cycle-by-cycle reference: start sampled at the end of cycle 0.
    function automatic void build_model();
        int k;
        int c;
        int a;
        for (int i = 0; i <= LAST; i++) exp_q[i] = '0;
        k = 255;
        for (int s = 0; s < 8; s++) begin
            int len  = 1 << s;
            int base = 1 + s * (128 + D);
            int idx  = 0;
            for (int cc = base; cc < base + 128 + D; cc++) exp_q[cc].stage = 4'(s);
            for (int g = 0; g < (128 >> s); g++) begin
                for (int o = 0; o < len; o++) begin
                    c = base + idx;
                    a = g * 2 * len + o;
                    exp_q[c].rd_en   = 1'b1;
                    exp_q[c].a       = 8'(a);
                    exp_q[c].b       = 8'(a + len);
                    exp_q[c].tw      = 8'(k);
                    exp_q[c+D].wa    = 1'b1;
                    exp_q[c+D].wb    = 1'b1;
                    exp_q[c+D].wra   = 8'(a);
                    exp_q[c+D].wrb   = 8'(a + len);
                    idx++;
                end
                k--;
            end
        end
`ifdef INTT_SCALE_EN
        begin
            int base = 1 + 8 * (128 + D);
            for (int cc = base; cc < DONE_CYC; cc++) exp_q[cc].stage = 4'd8;
            for (int i = 0; i < 256; i++) begin
                exp_q[base+i].rd_en = 1'b1;
                exp_q[base+i].a     = 8'(i);
                exp_q[base+i].sc    = 1'b1;
                exp_q[base+i+D].wb  = 1'b1;
                exp_q[base+i+D].wrb = 8'(i);
            end
        end
`endif
        for (int cc = 1; cc < DONE_CYC; cc++) exp_q[cc].busy = 1'b1;
        exp_q[DONE_CYC].done = 1'b1;
    endfunction

    task automatic add(input int cyc, input logic st, input out_t e);
        vec_t v;
        v.cyc = cyc; v.start = st; v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic check(input string nm, input out_t got, input out_t exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 20)
                $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // One run from its cycle 0 (start asserted) up to cycle 'last'.
    task automatic run(input int last, input bit use_tbl, input bit rnd);
        for (int c = 0; c <= last; c++) begin
            logic st;
            out_t got;
            got = sample();
            check($sformatf("model_c%0d", c), got, exp_q[c]);
            st = (c == 0);
            if (use_tbl) begin
                for (int i = 0; i < tbl.size(); i++) begin
                    if (tbl[i].cyc == c) begin
                        check($sformatf("tbl_c%0d", c), got, tbl[i].exp);
                        if (tbl[i].start) st = 1'b1;
                    end
                end
            end
            if (rnd && c >= 1 && c <= DONE_CYC && $urandom_range(0, 7) == 0) st = 1'b1;
            bus.start = st;
            if (c < last) begin
                @(posedge clk);
                #1;
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic pulse_reset();
        #1 rst_n = 1'b0;
        #1 check("async_reset", sample(), zero_o);
        #3 rst_n = 1'b1;
    endtask

    task automatic idle_check(input int n, input string nm);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check(nm, sample(), zero_o);
        end
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        zero_o    = '0;
        rst_n     = 1'b1;
        bus.start = 1'b0;
        build_model();

        add(0,    1'b1, mk(0,0,0, 0,   0,  0,  0, 0,0,   0,  0, 0));
        add(1,    1'b0, mk(1,0,0, 1,   0,  1,255, 0,0,   0,  0, 0));
        add(2,    1'b0, mk(1,0,0, 1,   2,  3,254, 0,0,   0,  0, 0));
        add(38,   1'b0, mk(1,0,0, 1,  74, 75,218, 1,1,   0,  1, 0));
        add(50,   1'b1, mk(1,0,0, 1,  98, 99,206, 1,1,  24, 25, 0));
        add(128,  1'b0, mk(1,0,0, 1, 254,255,128, 1,1, 180,181, 0));
        add(129,  1'b0, mk(1,0,0, 0,   0,  0,  0, 1,1, 182,183, 0));
        add(165,  1'b0, mk(1,0,0, 0,   0,  0,  0, 1,1, 254,255, 0));
        add(166,  1'b0, mk(1,0,1, 1,   0,  2,127, 0,0,   0,  0, 0));
        add(167,  1'b0, mk(1,0,1, 1,   1,  3,127, 0,0,   0,  0, 0));
        add(168,  1'b0, mk(1,0,1, 1,   4,  6,126, 0,0,   0,  0, 0));
        add(1156, 1'b0, mk(1,0,7, 1,   0,128,  1, 0,0,   0,  0, 0));
        add(1283, 1'b0, mk(1,0,7, 1, 127,255,  1, 1,1,  90,218, 0));
        add(1320, 1'b0, mk(1,0,7, 0,   0,  0,  0, 1,1, 127,255, 0));
`ifdef INTT_SCALE_EN
        add(1321, 1'b0, mk(1,0,8, 1,   0,  0,  0, 0,0,   0,  0, 1));
        add(1322, 1'b0, mk(1,0,8, 1,   1,  0,  0, 0,0,   0,  0, 1));
        add(1613, 1'b0, mk(1,0,8, 0,   0,  0,  0, 0,1,   0,255, 0));
        add(1614, 1'b1, mk(0,1,0, 0,   0,  0,  0, 0,0,   0,  0, 0));
        add(1615, 1'b0, mk(0,0,0, 0,   0,  0,  0, 0,0,   0,  0, 0));
`else
        add(1321, 1'b1, mk(0,1,0, 0,   0,  0,  0, 0,0,   0,  0, 0));
        add(1322, 1'b0, mk(0,0,0, 0,   0,  0,  0, 0,0,   0,  0, 0));
`endif

        // Power-on reset.
        #1 rst_n = 1'b0;
        #9 check("reset_state", sample(), zero_o);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full directed run with ignored start pulses.
        run(LAST, 1'b1, 1'b0);

        // Abort at cycle 600, restart at cycle 610.
        @(posedge clk);
        #1;
        run(600, 1'b0, 1'b0);
        pulse_reset();
        idle_check(10, "post_reset_idle");
        run(LAST, 1'b0, 1'b0);

        // Random aborts, idle gaps and stray start pulses while busy.
        for (int it = 0; it < 3; it++) begin
            int r;
            r = $urandom_range(2, DONE_CYC - 1);
            @(posedge clk);
            #1;
            run(r, 1'b0, 1'b1);
            pulse_reset();
            idle_check($urandom_range(2, 12), "rand_reset_idle");
            run(LAST, 1'b0, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
